// File: rtl/alu_pkg.sv
// Opcode and engine-state definitions shared by the execute-stage ALU and its mult/div engine.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_SLTU  = 5'b00011,
    OP_SLL   = 5'b00100,
    OP_SRL   = 5'b00101,
    OP_SRA   = 5'b00110,
    OP_XOR   = 5'b00111,
    OP_NOR   = 5'b01000,
    OP_SUB   = 5'b01010,
    OP_SLT   = 5'b01011,
    OP_SLLV  = 5'b01100,
    OP_SRLV  = 5'b01101,
    OP_SRAV  = 5'b01110,
    OP_MULT  = 5'b10000,
    OP_MULTU = 5'b10001,
    OP_DIV   = 5'b10010,
    OP_DIVU  = 5'b10011,
    OP_MFHI  = 5'b10100,
    OP_MFLO  = 5'b10101,
    OP_MTHI  = 5'b10110,
    OP_MTLO  = 5'b10111
  } op_t;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_t;

  function automatic logic is_md_op(op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/alu_mdu_seq.sv
// Iterative radix-2 multiply / restoring divide engine that owns HI/LO.
// Operands are taken as magnitudes; the sign fix-up happens on the last iteration edge.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t state, state_nxt;

  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   wh, wl, m, a_orig;
  logic               is_div, neg_q, neg_r, b_zero;
  logic               last, fin, go, sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, t, r;
  logic               ge;
  logic [WIDTH-1:0]   step_h, step_l, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;

  assign sgn   = ~op[0];
  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;
  assign last  = (state == MD_RUN) && (cnt == SHW'(WIDTH - 1));
  assign go    = start & ~flush;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = MD_IDLE;
    else begin
      case (state)
        MD_IDLE: if (start) state_nxt = MD_RUN;
        MD_RUN:  if (last)  state_nxt = MD_IDLE;
        default: state_nxt = MD_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == MD_RUN);
    fin  = last & ~flush;
  end

  // One iteration: multiply shifts {wh,wl} right after a conditional add,
  // divide shifts the dividend into the partial remainder and trial-subtracts.
  always_comb begin
    sum = {1'b0, wh} + (wl[0] ? {1'b0, m} : '0);
    t   = {wh, wl[WIDTH-1]};
    ge  = (t >= {1'b0, m});
    r   = ge ? (t - {1'b0, m}) : t;
    if (is_div) begin
      step_h = r[WIDTH-1:0];
      step_l = {wl[WIDTH-2:0], ge};
    end else begin
      step_h = sum[WIDTH:1];
      step_l = {sum[0], wl[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = neg_q ? -{step_h, step_l} : {step_h, step_l};
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        fin_lo = '1;
        fin_hi = a_orig;
      end else begin
        fin_lo = neg_q ? -step_l : step_l;
        fin_hi = neg_r ? -step_h : step_h;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      wh      <= '0;
      wl      <= '0;
      m       <= '0;
      a_orig  <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      md_done <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      md_done <= fin;
      if (go && state == MD_IDLE) begin
        cnt    <= '0;
        wh     <= '0;
        wl     <= mag_a;
        m      <= mag_b;
        a_orig <= a;
        is_div <= op[1];
        neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= sgn & a[WIDTH-1];
        b_zero <= (b == '0);
      end else if (state == MD_RUN) begin
        wh  <= step_h;
        wl  <= step_l;
        cnt <= cnt + 1'b1;
      end
      if (fin) begin
        hi <= fin_hi;
        lo <= fin_lo;
      end else begin
        if (mt_hi) hi <= a;
        if (mt_lo) lo <= a;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: registered single-cycle datapath plus the iterative HI/LO engine.
// in_ready drops while the engine iterates so the hazard unit can stall the pipe.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             md_done
);

  op_t              opc;
  logic             accept, md_start, mt_hi, mt_lo, sc_op, ov;
  logic [WIDTH-1:0] hi, lo, res, sum, diff;
  logic [SHW-1:0]   sh;

  assign opc      = op_t'(op);
  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready;
  assign md_start = accept & is_md_op(opc);
  assign mt_hi    = accept & (opc == OP_MTHI);
  assign mt_lo    = accept & (opc == OP_MTLO);
  assign sc_op    = accept & ~is_md_op(opc) & ~mt_hi & ~mt_lo;

  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = (opc inside {OP_SLLV, OP_SRLV, OP_SRAV}) ? a[SHW-1:0] : shamt;

  alu_mdu_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .flush   (flush),
    .op      (op),
    .a       (a),
    .b       (b),
    .mt_hi   (mt_hi),
    .mt_lo   (mt_lo),
    .busy    (busy),
    .md_done (md_done),
    .hi      (hi),
    .lo      (lo)
  );

  // Overflow only when both addends (or a and -b) share a sign the result lost.
  always_comb begin
    res = '0;
    ov  = 1'b0;
    case (opc)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_ADD: begin
        res = sum;
        ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SLLV: res = b << sh;
      OP_SRL, OP_SRLV: res = b >> sh;
      OP_SRA, OP_SRAV: res = $signed(b) >>> sh;
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
    end else begin
      out_valid <= sc_op;
      if (sc_op) begin
        y    <= res;
        zero <= (res == '0);
        ovf  <= ov;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised self-checking bench for alu_mdu against a plain-arithmetic reference model.
module tb_alu_mdu;
  localparam int W   = 32;
  localparam int SHW = 5;
  localparam longint SMAX = (64'sd1 <<< (W-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W-1));

  logic clk = 0, reset_n = 0, in_valid = 0, flush = 0;
  logic [4:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic [SHW-1:0] shamt = 0;
  logic in_ready, out_valid, zero, ovf, busy, md_done;
  logic [W-1:0] y;

  int total = 0, bad = 0;
  logic [W-1:0] m_hi = 0, m_lo = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W), .SHW(SHW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt), .flush(flush),
    .out_valid(out_valid), .y(y), .zero(zero), .ovf(ovf), .busy(busy), .md_done(md_done)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] yv,
                       input logic [SHW-1:0] s);
    op = o; a = x; b = yv; shamt = s; in_valid = 1;
  endtask

  function automatic void model_sc(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] yv,
                                   input logic [SHW-1:0] s, output logic [W-1:0] r,
                                   output logic ov, output logic v);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(yv));
    longint t;
    r = 0; ov = 0; v = 1;
    case (o)
      5'h00: r = x & yv;
      5'h01: r = x | yv;
      5'h07: r = x ^ yv;
      5'h08: r = ~(x | yv);
      5'h02: begin t = sx + sy; r = t[W-1:0]; ov = (t > SMAX) || (t < SMIN); end
      5'h0A: begin t = sx - sy; r = t[W-1:0]; ov = (t > SMAX) || (t < SMIN); end
      5'h03: r = (x < yv) ? 1 : 0;
      5'h0B: r = (sx < sy) ? 1 : 0;
      5'h04: r = yv << s;
      5'h05: r = yv >> s;
      5'h06: r = W'(sy >>> s);
      5'h0C: r = yv << x[SHW-1:0];
      5'h0D: r = yv >> x[SHW-1:0];
      5'h0E: r = W'(sy >>> x[SHW-1:0]);
      5'h14: r = m_hi;
      5'h15: r = m_lo;
      5'h16, 5'h17: v = 0;
      default: r = 0;
    endcase
  endfunction

  function automatic void model_md(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] yv,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(yv));
    logic [2*W-1:0] p;
    h = 0; l = 0;
    case (o)
      5'h10: begin p = sx * sy; h = p[2*W-1:W]; l = p[W-1:0]; end
      5'h11: begin p = 64'(x) * 64'(yv); h = p[2*W-1:W]; l = p[W-1:0]; end
      5'h12: if (yv == 0) begin l = '1; h = x; end
             else begin l = W'(sx / sy); h = W'(sx % sy); end
      default: if (yv == 0) begin l = '1; h = x; end
               else begin l = x / yv; h = x % yv; end
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 0; in_valid = 0;
    step(); step();
    reset_n = 1;
    total++; if (out_valid !== 0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (y !== 0) begin bad++; $display("FAIL reset_y got=%h exp=0", y); end
    total++; if (zero !== 1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
    total++; if (ovf !== 0 || busy !== 0 || md_done !== 0) begin bad++;
      $display("FAIL reset_flags got ovf=%b busy=%b md_done=%b exp=000", ovf, busy, md_done); end
    total++; if (in_ready !== 1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    drive(5'h02, 32'h7FFFFFFF, 32'h1, 0); step();
    total++; if (out_valid !== 1 || y !== 32'h80000000 || ovf !== 1 || zero !== 0) begin bad++;
      $display("FAIL add_ovf got v=%b y=%h ovf=%b z=%b exp v=1 y=80000000 ovf=1 z=0", out_valid, y, ovf, zero); end
    drive(5'h0A, 5, 5, 0); step();
    total++; if (y !== 0 || zero !== 1 || ovf !== 0) begin bad++;
      $display("FAIL sub_zero got y=%h z=%b ovf=%b exp y=0 z=1 ovf=0", y, zero, ovf); end
    drive(5'h0B, 32'h80000000, 1, 0); step();
    total++; if (y !== 1) begin bad++; $display("FAIL slt_min got=%h exp=1", y); end
    drive(5'h03, 32'h80000000, 1, 0); step();
    total++; if (y !== 0 || zero !== 1) begin bad++; $display("FAIL sltu_min got y=%h z=%b exp y=0 z=1", y, zero); end
    drive(5'h06, 0, 32'hF0000000, 4); step();
    total++; if (y !== 32'hFF000000) begin bad++; $display("FAIL sra got=%h exp=ff000000", y); end
    drive(5'h1F, 32'h1234, 32'h5678, 0); step();
    total++; if (out_valid !== 1 || y !== 0) begin bad++; $display("FAIL undef_op got v=%b y=%h exp v=1 y=0", out_valid, y); end
    in_valid = 0; step();
    total++; if (out_valid !== 0) begin bad++; $display("FAIL idle_no_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] codes [0:25] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                                 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h14, 5'h15, 5'h16, 5'h17,
                                 5'h09, 5'h0F, 5'h18, 5'h1F, 5'h02, 5'h0A, 5'h0B, 5'h03};
    logic [W-1:0] specials [0:4] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1};
    logic [4:0] o; logic [W-1:0] x, yv, er; logic [SHW-1:0] s; logic eo, ev;
    for (int i = 0; i < 300; i++) begin
      o  = codes[$urandom_range(0, 25)];
      x  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      yv = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      if ($urandom_range(0, 7) == 0) yv = x;
      s  = SHW'($urandom);
      model_sc(o, x, yv, s, er, eo, ev);
      drive(o, x, yv, s); step();
      if (o == 5'h16) m_hi = x;
      if (o == 5'h17) m_lo = x;
      total++; if (out_valid !== ev) begin bad++;
        $display("FAIL b2b_valid op=%h got=%b exp=%b", o, out_valid, ev); end
      if (ev) begin
        total++; if (y !== er || zero !== (er == 0) || ovf !== eo) begin bad++;
          $display("FAIL b2b_result op=%h a=%h b=%h sh=%0d got y=%h z=%b ovf=%b exp y=%h z=%b ovf=%b",
                   o, x, yv, s, y, zero, ovf, er, (er == 0), eo); end
      end
    end
    in_valid = 0; step();
  endtask

  task automatic md_op(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] yv);
    logic [W-1:0] eh, el; int cyc; logic stalled_ok;
    model_md(o, x, yv, eh, el);
    drive(o, x, yv, 0); step();
    total++; if (busy !== 1 || in_ready !== 0) begin bad++;
      $display("FAIL md_busy op=%h got busy=%b rdy=%b exp busy=1 rdy=0", o, busy, in_ready); end
    op = 5'h14;
    cyc = 1; stalled_ok = 1;
    while (md_done !== 1 && cyc < 100) begin
      if (out_valid !== 0) stalled_ok = 0;
      step(); cyc++;
    end
    if (out_valid !== 0) stalled_ok = 0;
    total++; if (cyc !== W + 1) begin bad++; $display("FAIL md_latency op=%h got=%0d exp=%0d", o, cyc, W + 1); end
    total++; if (busy !== 0 || stalled_ok !== 1) begin bad++;
      $display("FAIL md_stall op=%h got busy=%b stall_ok=%b exp busy=0 stall_ok=1", o, busy, stalled_ok); end
    m_hi = eh; m_lo = el;
    step();
    total++; if (out_valid !== 1 || y !== m_hi) begin bad++;
      $display("FAIL md_hi op=%h a=%h b=%h got v=%b y=%h exp v=1 y=%h", o, x, yv, out_valid, y, m_hi); end
    op = 5'h15; step();
    total++; if (y !== m_lo) begin bad++;
      $display("FAIL md_lo op=%h a=%h b=%h got=%h exp=%h", o, x, yv, y, m_lo); end
    in_valid = 0; step();
  endtask

  task automatic test_md();
    logic [W-1:0] x, yv; logic [4:0] o;
    md_op(5'h10, -32'sd3, 32'd7);
    md_op(5'h12, -32'sd7, 32'd2);
    md_op(5'h13, 32'd9, 32'd0);
    md_op(5'h12, 32'h80000000, 32'hFFFFFFFF);
    md_op(5'h12, -32'sd7, 32'd0);
    md_op(5'h10, 32'h80000000, 32'h80000000);
    md_op(5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) begin
      o  = 5'h10 + 5'($urandom_range(0, 3));
      x  = W'($urandom);
      yv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
      if ($urandom_range(0, 1) == 0) yv = -yv;
      md_op(o, x, yv);
    end
  endtask

  task automatic test_flush();
    int seen;
    drive(5'h16, 32'h1234, 0, 0); step();
    m_hi = 32'h1234;
    drive(5'h11, W'($urandom), W'($urandom), 0); step();
    in_valid = 0;
    repeat (10) step();
    flush = 1; step(); flush = 0;
    total++; if (busy !== 0 || md_done !== 0 || in_ready !== 1) begin bad++;
      $display("FAIL flush_abort got busy=%b done=%b rdy=%b exp 0 0 1", busy, md_done, in_ready); end
    seen = 0;
    repeat (40) begin step(); if (md_done !== 0) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    drive(5'h14, 0, 0, 0); step();
    total++; if (y !== 32'h1234) begin bad++; $display("FAIL flush_hi got=%h exp=00001234", y); end
    drive(5'h15, 0, 0, 0); step();
    total++; if (y !== m_lo) begin bad++; $display("FAIL flush_lo got=%h exp=%h", y, m_lo); end
    drive(5'h02, 3, 4, 0); flush = 1; step();
    total++; if (out_valid !== 1 || y !== 7) begin bad++;
      $display("FAIL flush_sc_accept got v=%b y=%h exp v=1 y=7", out_valid, y); end
    drive(5'h10, 5, 5, 0); step(); flush = 0;
    total++; if (busy !== 0) begin bad++; $display("FAIL flush_md_drop got busy=%b exp=0", busy); end
    in_valid = 0; step();
  endtask

  task automatic test_reset_mid();
    drive(5'h12, W'($urandom), 32'd3, 0); step();
    in_valid = 0;
    repeat (5) step();
    reset_n = 0; drive(5'h02, 1, 1, 0); step(); reset_n = 1; in_valid = 0;
    m_hi = 0; m_lo = 0;
    total++; if (busy !== 0 || out_valid !== 0 || zero !== 1 || y !== 0 || md_done !== 0) begin bad++;
      $display("FAIL mid_reset got busy=%b v=%b z=%b y=%h done=%b exp 0 0 1 0 0", busy, out_valid, zero, y, md_done); end
    drive(5'h15, 0, 0, 0); step();
    total++; if (out_valid !== 1 || y !== 0) begin bad++; $display("FAIL mid_reset_lo got v=%b y=%h exp v=1 y=0", out_valid, y); end
    drive(5'h14, 0, 0, 0); step();
    total++; if (y !== 0 || zero !== 1) begin bad++; $display("FAIL mid_reset_hi got y=%h z=%b exp y=0 z=1", y, zero); end
    in_valid = 0; step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_md();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
